// File: rtl/jesd204_emb_pkg.sv
// Shared types and constants for the JESD204C receive-lane extended-multiblock
// alignment stage.
package jesd204_emb_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LOCK    = 2'd3
    } emb_state_e;

    localparam logic [1:0] SH_BIT0 = 2'b01;
    localparam logic [1:0] SH_BIT1 = 2'b10;

    // Bits 27..30 are zero and bit 31 is one in a valid end-of-multiblock marker
    localparam int          EOMB_POS       = 27;
    localparam int          EOEMB_POS      = 22;
    localparam logic [31:0] EOMB_ZERO_MASK = 32'h0000_000F << EOMB_POS;
    localparam logic [31:0] EOMB_ONE_MASK  = 32'h0000_0001 << (EOMB_POS + 4);

    // Separator bits at positions 3, 7, 11, 15, 19 and 23 are always one
    localparam logic [31:0] SEP_MASK        = 32'h0088_8888;
    localparam logic [31:0] EOMB_CHECK_MASK = EOMB_ZERO_MASK | EOMB_ONE_MASK | SEP_MASK;
    localparam logic [31:0] EOMB_CHECK_VAL  = EOMB_ONE_MASK | SEP_MASK;

    function automatic logic sh_invalid(input logic [1:0] hdr);
        return (hdr != SH_BIT0) && (hdr != SH_BIT1);
    endfunction

endpackage

// File: rtl/jesd204_sh_word_extract.sv
// Sync-header bit extraction: decodes each header to one multiblock bit,
// shifts it into a 32-bit word and slices the marker and field bits from it.
module jesd204_sh_word_extract
    import jesd204_emb_pkg::*;
(
    input  logic        usr_clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic [1:0]  rx_header,
    output logic        sh_err,
    output logic        eomb_match,
    output logic        eoemb,
    output logic [11:0] crc12,
    output logic [7:0]  cmd
);

    logic [31:0] sr_r;
    logic        sh_err_r;
    logic        hdr_bit_s;
    logic        hdr_bad_s;

    // Invalid headers (00/11) decode as zero
    assign hdr_bit_s = (rx_header == SH_BIT1);
    assign hdr_bad_s = sh_invalid(rx_header);

    // Oldest bit ends at sr_r[0], so after a full multiblock sr_r[k] holds bit k
    always_ff @(posedge usr_clk) begin
        if (!resetn) begin
            sr_r     <= 32'd0;
            sh_err_r <= 1'b0;
        end else if (clear) begin
            sr_r     <= 32'd0;
            sh_err_r <= 1'b0;
        end else begin
            sr_r     <= {hdr_bit_s, sr_r[31:1]};
            sh_err_r <= hdr_bad_s;
        end
    end

    assign sh_err     = sh_err_r;
    assign eomb_match = ((sr_r & EOMB_CHECK_MASK) == EOMB_CHECK_VAL);
    assign eoemb      = sr_r[EOEMB_POS];
    assign crc12      = {sr_r[0],  sr_r[1],  sr_r[2],
                         sr_r[4],  sr_r[5],  sr_r[6],
                         sr_r[8],  sr_r[9],  sr_r[10],
                         sr_r[12], sr_r[13], sr_r[14]};
    assign cmd        = {sr_r[16], sr_r[17], sr_r[18],
                         sr_r[20], sr_r[21],
                         sr_r[24], sr_r[25], sr_r[26]};

endmodule

// File: rtl/jesd204_rx_emb_align.sv
// JESD204C 64B66B receive lane: multiblock hunt/confirm/lock FSM, block
// counter and registered EoMB, CRC-12 and command outputs.
module jesd204_rx_emb_align
    import jesd204_emb_pkg::*;
#(
    parameter int CONFIRM_CNT = 4,
    parameter int LOSS_CNT    = 4
) (
    input  logic        usr_clk,
    input  logic        resetn,
    input  logic [63:0] rx_data,
    input  logic [1:0]  rx_header,
    input  logic        rx_block_sync,
    output logic [63:0] o_data,
    output logic [4:0]  o_blk_idx,
    output logic        o_eomb,
    output logic        o_eoemb,
    output logic [11:0] o_crc12,
    output logic [7:0]  o_cmd,
    output logic        o_emb_lock,
    output logic        o_sh_err
);

    localparam logic [3:0] CONFIRM_TGT = 4'(CONFIRM_CNT);
    localparam logic [3:0] LOSS_TGT    = 4'(LOSS_CNT);

    emb_state_e  state_r;
    emb_state_e  state_nx_s;
    logic [3:0]  good_cnt_r;
    logic [3:0]  good_cnt_nx_s;
    logic [3:0]  bad_cnt_r;
    logic [3:0]  bad_cnt_nx_s;
    logic [4:0]  blk_cnt_r;
    logic [4:0]  blk_cnt_nx_s;
    logic        emit_s;
    logic        check_s;
    logic        eomb_match_s;
    logic        eoemb_s;
    logic        sh_err_s;
    logic [11:0] crc12_s;
    logic [7:0]  cmd_s;
    logic [63:0] data_d1_r;

    jesd204_sh_word_extract u_extract (
        .usr_clk    (usr_clk),
        .resetn     (resetn),
        .clear      (~rx_block_sync),
        .rx_header  (rx_header),
        .sh_err     (sh_err_s),
        .eomb_match (eomb_match_s),
        .eoemb      (eoemb_s),
        .crc12      (crc12_s),
        .cmd        (cmd_s)
    );

    assign check_s = (blk_cnt_r == 5'd31);

    // Next-state, counter and EoMB-emit decode; loss of block sync overrides all
    always_comb begin
        state_nx_s    = state_r;
        good_cnt_nx_s = good_cnt_r;
        bad_cnt_nx_s  = bad_cnt_r;
        blk_cnt_nx_s  = blk_cnt_r + 5'd1;
        emit_s        = 1'b0;

        case (state_r)
            ST_INIT: begin
                if (rx_block_sync) begin
                    state_nx_s = ST_HUNT;
                end else begin
                    state_nx_s = ST_INIT;
                end
            end
            ST_HUNT: begin
                if (eomb_match_s) begin
                    state_nx_s    = ST_CONFIRM;
                    good_cnt_nx_s = 4'd1;
                    blk_cnt_nx_s  = 5'd0;
                end else begin
                    state_nx_s = ST_HUNT;
                end
            end
            ST_CONFIRM: begin
                if (!check_s) begin
                    state_nx_s = ST_CONFIRM;
                end else if (!eomb_match_s) begin
                    state_nx_s    = ST_HUNT;
                    good_cnt_nx_s = 4'd0;
                end else if ((good_cnt_r + 4'd1) == CONFIRM_TGT) begin
                    // The marker that completes confirmation is delivered as a real EoMB
                    state_nx_s    = ST_LOCK;
                    good_cnt_nx_s = 4'd0;
                    bad_cnt_nx_s  = 4'd0;
                    emit_s        = 1'b1;
                end else begin
                    good_cnt_nx_s = good_cnt_r + 4'd1;
                end
            end
            ST_LOCK: begin
                if (!check_s) begin
                    state_nx_s = ST_LOCK;
                end else if (eomb_match_s) begin
                    bad_cnt_nx_s = 4'd0;
                    emit_s       = 1'b1;
                end else if ((bad_cnt_r + 4'd1) == LOSS_TGT) begin
                    state_nx_s   = ST_HUNT;
                    bad_cnt_nx_s = 4'd0;
                end else begin
                    bad_cnt_nx_s = bad_cnt_r + 4'd1;
                end
            end
            default: begin
                state_nx_s = ST_INIT;
            end
        endcase

        if (!rx_block_sync) begin
            state_nx_s    = ST_INIT;
            good_cnt_nx_s = 4'd0;
            bad_cnt_nx_s  = 4'd0;
            blk_cnt_nx_s  = 5'd0;
            emit_s        = 1'b0;
        end else begin
            emit_s = emit_s;
        end
    end

    // FSM state and alignment counters
    always_ff @(posedge usr_clk) begin
        if (!resetn) begin
            state_r    <= ST_INIT;
            good_cnt_r <= 4'd0;
            bad_cnt_r  <= 4'd0;
            blk_cnt_r  <= 5'd0;
        end else begin
            state_r    <= state_nx_s;
            good_cnt_r <= good_cnt_nx_s;
            bad_cnt_r  <= bad_cnt_nx_s;
            blk_cnt_r  <= blk_cnt_nx_s;
        end
    end

    // Lane outputs; fields hold their last good value between EoMB pulses
    always_ff @(posedge usr_clk) begin
        if (!resetn) begin
            o_blk_idx  <= 5'd0;
            o_eomb     <= 1'b0;
            o_eoemb    <= 1'b0;
            o_crc12    <= 12'd0;
            o_cmd      <= 8'd0;
            o_emb_lock <= 1'b0;
            o_sh_err   <= 1'b0;
        end else begin
            o_blk_idx  <= rx_block_sync ? blk_cnt_r : 5'd0;
            o_eomb     <= emit_s;
            o_eoemb    <= emit_s & eoemb_s;
            o_emb_lock <= (state_nx_s == ST_LOCK);
            o_sh_err   <= sh_err_s;
            if (emit_s) begin
                o_crc12 <= crc12_s;
                o_cmd   <= cmd_s;
            end else begin
                o_crc12 <= o_crc12;
                o_cmd   <= o_cmd;
            end
        end
    end

    // Two-stage data pipe keeps block 31 aligned with its EoMB pulse
    always_ff @(posedge usr_clk) begin
        if (!resetn) begin
            data_d1_r <= 64'd0;
            o_data    <= 64'd0;
        end else begin
            data_d1_r <= rx_data;
            o_data    <= data_d1_r;
        end
    end

endmodule

// File: tb/tb_jesd204_rx_emb_align.sv
// Directed self-checking bench for jesd204_rx_emb_align: multiblock streams
// with hand-computed marker/field values and expected lock timing.
module tb_jesd204_rx_emb_align;

    // Multiblock word: CRC=0xA5C, cmd=0x3B, EoEMB=0, separators and marker valid
    localparam logic [31:0] W_BASE = 32'h86BC_9ECD;
    localparam logic [31:0] W_EO   = 32'h86FC_9ECD;
    localparam logic [31:0] W_BAD  = 32'h06BC_9ECD;
    localparam int EV_NONE   = 0;
    localparam int EV_DROP   = 1;
    localparam int EV_RST    = 2;
    localparam int EV_BADHDR = 3;

    logic        usr_clk;
    logic        resetn;
    logic [63:0] rx_data;
    logic [1:0]  rx_header;
    logic        rx_block_sync;
    logic [63:0] o_data;
    logic [4:0]  o_blk_idx;
    logic        o_eomb;
    logic        o_eoemb;
    logic [11:0] o_crc12;
    logic [7:0]  o_cmd;
    logic        o_emb_lock;
    logic        o_sh_err;

    int          n_chk;
    int          n_err;
    logic [15:0] mb_no;
    logic [63:0] hist_d;
    int          pulse_cnt, pulse_pos, eo_cnt, sh_cnt, sh_pos, data_bad;
    logic        lock0, cap_eo, ev_lock;
    logic [4:0]  cap_blk, blk5, ev_blk;
    logic [11:0] cap_crc, ev_crc;
    logic [7:0]  cap_cmd, ev_cmd;
    logic [63:0] cap_data, ev_data;

    jesd204_rx_emb_align dut (
        .usr_clk       (usr_clk),
        .resetn        (resetn),
        .rx_data       (rx_data),
        .rx_header     (rx_header),
        .rx_block_sync (rx_block_sync),
        .o_data        (o_data),
        .o_blk_idx     (o_blk_idx),
        .o_eomb        (o_eomb),
        .o_eoemb       (o_eoemb),
        .o_crc12       (o_crc12),
        .o_cmd         (o_cmd),
        .o_emb_lock    (o_emb_lock),
        .o_sh_err      (o_sh_err)
    );

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sends one 32-block multiblock and records what the DUT shows; sample 0
    // carries the boundary result of the previous multiblock.
    task automatic send_mb(input logic [31:0] word, input int ev_kind, input int ev_at);
        logic [63:0] exp_d;
        pulse_cnt = 0; pulse_pos = -1; eo_cnt = 0; sh_cnt = 0; sh_pos = -1; data_bad = 0;
        for (int k = 0; k < 32; k++) begin
            rx_header     = word[k] ? 2'b10 : 2'b01;
            rx_data       = {16'hDA7A, mb_no, 32'(k)};
            rx_block_sync = 1'b1;
            resetn        = 1'b1;
            if (k == ev_at) begin
                case (ev_kind)
                    EV_DROP:   rx_block_sync = 1'b0;
                    EV_RST:    resetn = 1'b0;
                    EV_BADHDR: rx_header = 2'b11;
                    default:   rx_header = rx_header;
                endcase
            end
            @(posedge usr_clk);
            #1;
            if (k == ev_at && ev_kind == EV_RST) begin
                exp_d  = 64'd0;
                hist_d = 64'd0;
            end else begin
                exp_d  = hist_d;
                hist_d = rx_data;
            end
            if (o_data !== exp_d) data_bad++;
            if (k == 0) lock0 = o_emb_lock;
            if (k == 5) blk5 = o_blk_idx;
            if (o_eomb === 1'b1) begin
                pulse_cnt++;
                pulse_pos = k;
                cap_blk   = o_blk_idx;
                cap_crc   = o_crc12;
                cap_cmd   = o_cmd;
                cap_eo    = o_eoemb;
                cap_data  = o_data;
            end
            if (o_eoemb === 1'b1) eo_cnt++;
            if (o_sh_err === 1'b1) begin
                sh_cnt++;
                sh_pos = k;
            end
            if (k == ev_at) begin
                ev_lock = o_emb_lock;
                ev_blk  = o_blk_idx;
                ev_crc  = o_crc12;
                ev_cmd  = o_cmd;
                ev_data = o_data;
            end
        end
        mb_no = mb_no + 16'd1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; rx_block_sync = 1'b1; rx_header = 2'b11; rx_data = 64'hFFFF_0000_FFFF_0000;
        repeat (3) @(posedge usr_clk);
        #1;
        hist_d = 64'd0;
        mb_no  = 16'd0;
        n_chk++; if (o_data !== 64'd0) begin n_err++; $display("FAIL reset_data: got %0h expected 0", o_data); end
        n_chk++; if (o_emb_lock !== 1'b0 || o_eomb !== 1'b0 || o_eoemb !== 1'b0) begin n_err++; $display("FAIL reset_flags: got lock=%0b eomb=%0b eoemb=%0b expected 0", o_emb_lock, o_eomb, o_eoemb); end
        n_chk++; if (o_crc12 !== 12'd0 || o_cmd !== 8'd0) begin n_err++; $display("FAIL reset_fields: got crc=%0h cmd=%0h expected 0", o_crc12, o_cmd); end
        n_chk++; if (o_blk_idx !== 5'd0 || o_sh_err !== 1'b0) begin n_err++; $display("FAIL reset_idx_err: got idx=%0d sh_err=%0b expected 0", o_blk_idx, o_sh_err); end
    endtask

    task automatic test_clean_lock();
        logic [63:0] exp_d;
        for (int i = 0; i < 6; i++) begin
            exp_d = {16'hDA7A, mb_no - 16'd1, 32'd31};
            send_mb(W_BASE, EV_NONE, -1);
            n_chk++; if (lock0 !== (i >= 4)) begin n_err++; $display("FAIL clean_lock[%0d]: got %0b expected %0b", i, lock0, (i >= 4)); end
            n_chk++; if (pulse_cnt != ((i >= 4) ? 1 : 0)) begin n_err++; $display("FAIL clean_pulses[%0d]: got %0d expected %0d", i, pulse_cnt, (i >= 4) ? 1 : 0); end
            n_chk++; if (data_bad != 0) begin n_err++; $display("FAIL clean_data_delay[%0d]: got %0d bad samples expected 0", i, data_bad); end
            if (i >= 4) begin
                n_chk++; if (pulse_pos != 0 || cap_blk !== 5'd31) begin n_err++; $display("FAIL clean_pos_idx[%0d]: got pos=%0d idx=%0d expected 0/31", i, pulse_pos, cap_blk); end
                n_chk++; if (cap_crc !== 12'hA5C) begin n_err++; $display("FAIL clean_crc[%0d]: got %0h expected a5c", i, cap_crc); end
                n_chk++; if (cap_cmd !== 8'h3B) begin n_err++; $display("FAIL clean_cmd[%0d]: got %0h expected 3b", i, cap_cmd); end
                n_chk++; if (cap_eo !== 1'b0) begin n_err++; $display("FAIL clean_eoemb[%0d]: got %0b expected 0", i, cap_eo); end
                n_chk++; if (cap_data !== exp_d) begin n_err++; $display("FAIL clean_blk31_data[%0d]: got %0h expected %0h", i, cap_data, exp_d); end
                n_chk++; if (blk5 !== 5'd4) begin n_err++; $display("FAIL clean_blk_idx[%0d]: got %0d expected 4", i, blk5); end
            end
        end
    endtask

    task automatic test_eoemb();
        logic exp_eo;
        for (int i = 0; i < 9; i++) begin
            send_mb((i < 8 && (i % 4) == 0) ? W_EO : W_BASE, EV_NONE, -1);
            if (i > 0) begin
                exp_eo = ((i - 1) % 4) == 0;
                n_chk++; if (pulse_cnt != 1) begin n_err++; $display("FAIL eoemb_pulse[%0d]: got %0d expected 1", i, pulse_cnt); end
                n_chk++; if (cap_eo !== exp_eo || eo_cnt != int'(exp_eo)) begin n_err++; $display("FAIL eoemb_flag[%0d]: got %0b (%0d) expected %0b", i, cap_eo, eo_cnt, exp_eo); end
                n_chk++; if (cap_crc !== 12'hA5C || cap_cmd !== 8'h3B) begin n_err++; $display("FAIL eoemb_fields[%0d]: got %0h/%0h expected a5c/3b", i, cap_crc, cap_cmd); end
            end
        end
    endtask

    task automatic test_loss_of_lock();
        logic exp_lock [9];
        int   exp_p    [9];
        exp_lock = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_p    = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int j = 0; j < 9; j++) begin
            send_mb((j < 4) ? W_BAD : W_BASE, EV_NONE, -1);
            n_chk++; if (lock0 !== exp_lock[j]) begin n_err++; $display("FAIL loss_lock[%0d]: got %0b expected %0b", j, lock0, exp_lock[j]); end
            n_chk++; if (pulse_cnt != exp_p[j]) begin n_err++; $display("FAIL loss_pulses[%0d]: got %0d expected %0d", j, pulse_cnt, exp_p[j]); end
        end
    endtask

    task automatic test_sh_err();
        send_mb(W_BASE, EV_BADHDR, 3);
        n_chk++; if (sh_cnt != 1 || sh_pos != 4) begin n_err++; $display("FAIL sh_err_pulse: got count=%0d pos=%0d expected 1/4", sh_cnt, sh_pos); end
        send_mb(W_BASE, EV_NONE, -1);
        n_chk++; if (pulse_cnt != 0 || lock0 !== 1'b1) begin n_err++; $display("FAIL sh_err_check: got pulses=%0d lock=%0b expected 0/1", pulse_cnt, lock0); end
        n_chk++; if (sh_cnt != 0) begin n_err++; $display("FAIL sh_err_clean: got %0d expected 0", sh_cnt); end
        send_mb(W_BASE, EV_NONE, -1);
        n_chk++; if (pulse_cnt != 1 || lock0 !== 1'b1) begin n_err++; $display("FAIL sh_err_recover: got pulses=%0d lock=%0b expected 1/1", pulse_cnt, lock0); end
    endtask

    // Shared by block-sync drop and reset: event in block 10, then a full re-hunt
    task automatic test_relock(input int ev_kind, input string tag);
        for (int j = 0; j < 6; j++) begin
            send_mb(W_BASE, (j == 0) ? ev_kind : EV_NONE, (j == 0) ? 10 : -1);
            n_chk++; if (lock0 !== (j == 0 || j == 5)) begin n_err++; $display("FAIL %s_lock[%0d]: got %0b expected %0b", tag, j, lock0, (j == 0 || j == 5)); end
            n_chk++; if (data_bad != 0) begin n_err++; $display("FAIL %s_data[%0d]: got %0d bad samples expected 0", tag, j, data_bad); end
            if (j == 0) begin
                n_chk++; if (ev_lock !== 1'b0 || ev_blk !== 5'd0) begin n_err++; $display("FAIL %s_event: got lock=%0b idx=%0d expected 0/0", tag, ev_lock, ev_blk); end
            end
            if (j == 5) begin
                n_chk++; if (pulse_cnt != 1 || cap_crc !== 12'hA5C) begin n_err++; $display("FAIL %s_relock: got pulses=%0d crc=%0h expected 1/a5c", tag, pulse_cnt, cap_crc); end
            end
        end
    endtask

    task automatic test_block_sync_drop();
        test_relock(EV_DROP, "drop");
    endtask

    task automatic test_reset_mid_lock();
        test_relock(EV_RST, "rst");
        // ev_* still hold the reset-cycle sample from the first multiblock
        n_chk++; if (ev_data !== 64'd0 || ev_crc !== 12'd0 || ev_cmd !== 8'd0) begin n_err++; $display("FAIL rst_zero: got data=%0h crc=%0h cmd=%0h expected 0", ev_data, ev_crc, ev_cmd); end
    endtask

    task automatic test_false_marker();
        logic exp_lock [8];
        exp_lock = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int j = 0; j < 8; j++) begin
            send_mb((j == 2) ? W_BAD : W_BASE, (j == 0) ? EV_RST : EV_NONE, (j == 0) ? 10 : -1);
            n_chk++; if (lock0 !== exp_lock[j]) begin n_err++; $display("FAIL false_marker_lock[%0d]: got %0b expected %0b", j, lock0, exp_lock[j]); end
            n_chk++; if (pulse_cnt != int'(exp_lock[j])) begin n_err++; $display("FAIL false_marker_pulses[%0d]: got %0d expected %0d", j, pulse_cnt, int'(exp_lock[j])); end
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        resetn = 1'b0; rx_block_sync = 1'b0; rx_header = 2'b00; rx_data = 64'd0;
        mb_no = 16'd0; hist_d = 64'd0;
        test_reset();
        test_clean_lock();
        test_eoemb();
        test_loss_of_lock();
        test_sh_err();
        test_block_sync_drop();
        test_reset_mid_lock();
        test_false_marker();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
